// File: rtl/ram_mp_pkg.sv
// Shared constants for the multi-port byte-addressed RAM: byte/word widths
// and the two FSM state encodings (CLEAR sweep and IDLE service).
package ram_mp_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int XLEN_WIDTH = 32;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_IDLE  = 1'b1;

endpackage

// File: rtl/ram_read_port.sv
// One read port: write-first forwarding against the concurrent write, a
// READ_LATENCY-deep pipeline, and the rd_data hold register.
module ram_read_port
    import ram_mp_pkg::*;
#(
    parameter int XLEN         = XLEN_WIDTH,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_fire,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [XLEN-1:0]            old_data,
    input  logic                       wr_fire,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic [XLEN/BYTE_WIDTH-1:0] wr_strb,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_valid
);
    localparam int NB = XLEN / BYTE_WIDTH;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    logic [XLEN-1:0] fwd_data;
    logic            vld_p1_q, vld_p1_d;
    logic [XLEN-1:0] data_p1_q, data_p1_d;

    // Any strobed write byte landing on a read byte's address replaces the stale array value.
    always_comb begin
        fwd_data = old_data;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB; j++) begin
                if (wr_fire && wr_strb[j] &&
                    ((rd_addr + addr_t'(i)) == (wr_addr + addr_t'(j)))) begin
                    fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[j*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        vld_p1_d = rd_fire;
    end

    // Stage p1: request captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic            vld_p2_q, vld_p2_d;
            logic [XLEN-1:0] data_p2_q, data_p2_d;

            always_comb begin
                data_p1_d = rd_fire ? fwd_data : data_p1_q;
                vld_p2_d  = vld_p1_q;
                data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
            end

            always_ff @(posedge clk) begin
                data_p1_q <= data_p1_d;
            end

            // Stage p2: output stage doubles as the hold register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_p2_q  <= 1'b0;
                    data_p2_q <= '0;
                end else begin
                    vld_p2_q  <= vld_p2_d;
                    data_p2_q <= data_p2_d;
                end
            end

            assign rd_valid = vld_p2_q;
            assign rd_data  = data_p2_q;
        end else begin : g_lat1
            always_comb begin
                data_p1_d = rd_fire ? fwd_data : data_p1_q;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_p1_q <= '0;
                end else begin
                    data_p1_q <= data_p1_d;
                end
            end

            assign rd_valid = vld_p1_q;
            assign rd_data  = data_p1_q;
        end
    endgenerate

endmodule

// File: rtl/ram_mp.sv
// Byte-addressed RAM with one unaligned write port, READ_PORTS unaligned read
// ports, and a word-per-cycle zeroing sweep after reset or on clear_req.
module ram_mp
    import ram_mp_pkg::*;
#(
    parameter int XLEN         = XLEN_WIDTH,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_PORTS   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    output logic                       ready,
    input  logic [READ_PORTS-1:0]      rd_en,
    input  logic [READ_PORTS*XLEN-1:0] rd_addr,
    output logic [READ_PORTS*XLEN-1:0] rd_data,
    output logic [READ_PORTS-1:0]      rd_valid,
    input  logic                       wr_en,
    input  logic [XLEN-1:0]            wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic [XLEN/BYTE_WIDTH-1:0] wr_strb
);
    localparam int NB    = XLEN / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int WORDS = (DEPTH + NB - 1) / NB;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    logic [BYTE_WIDTH-1:0]      mem [DEPTH];
    state_t                     state_q, state_d;
    addr_t                      ctr_q, ctr_d;
    logic                       wr_fire;
    logic [READ_PORTS-1:0]      rd_fire;
    logic [READ_PORTS*XLEN-1:0] old_data;
    logic                       unused_addr_hi;

    // Address bits above ADDR_WIDTH are don't-care.
    assign unused_addr_hi = ^{rd_addr, wr_addr};

    assign ready   = (state_q == ST_IDLE);
    assign wr_fire = wr_en & ready;
    assign rd_fire = rd_en & {READ_PORTS{ready}};

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ctr_q == addr_t'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + addr_t'(1);
                end
            end
            default: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ctr_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // The sweep owns the array while clearing; user writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            for (int k = 0; k < NB; k++) begin
                mem[addr_t'(int'(ctr_q) * NB + k)] <= '0;
            end
        end else if (wr_fire) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_strb[k]) begin
                    mem[wr_addr[ADDR_WIDTH-1:0] + addr_t'(k)] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        old_data = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int k = 0; k < NB; k++) begin
                old_data[p*XLEN + k*BYTE_WIDTH +: BYTE_WIDTH] =
                    mem[rd_addr[p*XLEN +: ADDR_WIDTH] + addr_t'(k)];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        ram_read_port #(
            .XLEN        (XLEN),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .READ_LATENCY(READ_LATENCY)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .rd_fire (rd_fire[p]),
            .rd_addr (rd_addr[p*XLEN +: ADDR_WIDTH]),
            .old_data(old_data[p*XLEN +: XLEN]),
            .wr_fire (wr_fire),
            .wr_addr (wr_addr[ADDR_WIDTH-1:0]),
            .wr_data (wr_data),
            .wr_strb (wr_strb),
            .rd_data (rd_data[p*XLEN +: XLEN]),
            .rd_valid(rd_valid[p])
        );
    end

endmodule
